// File: rtl/probador_registro_pkg.sv
// rtl/probador_registro_pkg.sv - shared FSM states, register mode codes and seed table
package probador_registro_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_GAP,
    ST_FIN
  } state_t;

  typedef enum logic [1:0] {
    MODO_SHIFT  = 2'b00,
    MODO_ROTATE = 2'b01,
    MODO_LOAD   = 2'b10,
    MODO_HOLD   = 2'b11
  } modo_t;

  localparam int          NUM_TESTS = 5;
  localparam logic [2:0]  LAST_TEST = 3'd4;

  // Parallel-load value for each test; the register models use the same table.
  function automatic logic [3:0] seed_of(input logic [2:0] id);
    logic [3:0] s;
    s = 4'hA;
    case (id)
      3'd0:    s = 4'hA;
      3'd1:    s = 4'h1;
      3'd2:    s = 4'h8;
      3'd3:    s = 4'h3;
      3'd4:    s = 4'hC;
      default: s = 4'hA;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/probador_registro.sv
// rtl/probador_registro.sv - sequencer driving five shift-register tests (load, run, gap)
module probador_registro
  import probador_registro_pkg::*;
#(
  parameter int         RUN_LEN = 8,
  parameter logic [7:0] PATTERN = 8'b1011_0010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [2:0] test_id,
  output logic [4:0] enb,
  output logic [1:0] modo,
  output logic       dir,
  output logic       s_in,
  output logic [3:0] d
);

  typedef struct packed {
    modo_t modo;
    logic  dir;
  } run_cfg_t;

  localparam logic [3:0] LAST_CNT = 4'(RUN_LEN - 1);

  function automatic run_cfg_t run_cfg(input logic [2:0] id);
    run_cfg_t c;
    c = '{modo: MODO_HOLD, dir: 1'b0};
    case (id)
      3'd0:    c = '{modo: MODO_HOLD,   dir: 1'b0};
      3'd1:    c = '{modo: MODO_SHIFT,  dir: 1'b0};
      3'd2:    c = '{modo: MODO_SHIFT,  dir: 1'b1};
      3'd3:    c = '{modo: MODO_ROTATE, dir: 1'b0};
      3'd4:    c = '{modo: MODO_ROTATE, dir: 1'b1};
      default: c = '{modo: MODO_HOLD,   dir: 1'b0};
    endcase
    return c;
  endfunction

  state_t     state, state_nxt;
  logic [2:0] id_nxt;
  logic [3:0] cnt, cnt_nxt;
  run_cfg_t   cfg_nxt;

  logic       busy_nxt, done_nxt, dir_nxt, s_in_nxt;
  logic [4:0] enb_nxt;
  logic [1:0] modo_nxt;
  logic [3:0] d_nxt;

  always_comb begin
    state_nxt = state;
    id_nxt    = test_id;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_LOAD;
          id_nxt    = 3'd0;
        end
      end
      ST_LOAD: begin
        state_nxt = ST_RUN;
        cnt_nxt   = 4'd0;
      end
      ST_RUN: begin
        if (cnt == LAST_CNT) begin
          state_nxt = ST_GAP;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      ST_GAP: begin
        if (test_id < LAST_TEST) begin
          state_nxt = ST_LOAD;
          id_nxt    = test_id + 3'd1;
        end else begin
          state_nxt = ST_FIN;
        end
      end
      ST_FIN: begin
        if (start) begin
          state_nxt = ST_LOAD;
          id_nxt    = 3'd0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        id_nxt    = 3'd0;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it,
  // so they line up with the state they describe and never see START directly.
  always_comb begin
    cfg_nxt  = run_cfg(id_nxt);
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    enb_nxt  = 5'b0;
    modo_nxt = MODO_HOLD;
    dir_nxt  = 1'b0;
    s_in_nxt = 1'b0;
    d_nxt    = seed_of(id_nxt);
    case (state_nxt)
      ST_LOAD: begin
        busy_nxt = 1'b1;
        enb_nxt  = 5'b00001 << id_nxt;
        modo_nxt = MODO_LOAD;
      end
      ST_RUN: begin
        busy_nxt = 1'b1;
        enb_nxt  = 5'b00001 << id_nxt;
        modo_nxt = cfg_nxt.modo;
        dir_nxt  = cfg_nxt.dir;
        s_in_nxt = PATTERN[3'd7 - cnt_nxt[2:0]];
      end
      ST_GAP: begin
        busy_nxt = 1'b1;
      end
      ST_FIN: begin
        done_nxt = 1'b1;
      end
      default: begin
        busy_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      test_id <= 3'd0;
      cnt     <= 4'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      enb     <= 5'b0;
      modo    <= MODO_HOLD;
      dir     <= 1'b0;
      s_in    <= 1'b0;
      d       <= seed_of(3'd0);
    end else begin
      state   <= state_nxt;
      test_id <= id_nxt;
      cnt     <= cnt_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      enb     <= enb_nxt;
      modo    <= modo_nxt;
      dir     <= dir_nxt;
      s_in    <= s_in_nxt;
      d       <= d_nxt;
    end
  end

endmodule

// File: tb/tb_probador_registro.sv
// tb/tb_probador_registro.sv - scoreboard bench for probador_registro at RUN_LEN 8 and 1
module tb_probador_registro;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [2:0] test_id;
    logic [4:0] enb;
    logic [1:0] modo;
    logic       dir;
    logic       s_in;
    logic [3:0] d;
  } obs_t;

  typedef struct packed {
    obs_t e8;
    obs_t e1;
  } entry_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;

  obs_t o8, o1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  entry_t sb [$];

  logic [3:0] seed_tbl [5] = '{4'hA, 4'h1, 4'h8, 4'h3, 4'hC};
  logic [1:0] modo_tbl [5] = '{2'b11, 2'b00, 2'b00, 2'b01, 2'b01};
  logic       dir_tbl  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic       pat_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  int ph8 = 0, t8 = 0, ph1 = 0, t1 = 0;

  always #5 clk = ~clk;

  probador_registro #(.RUN_LEN(8)) dut8 (
    .clk(clk), .reset(reset), .start(start),
    .busy(o8.busy), .done(o8.done), .test_id(o8.test_id), .enb(o8.enb),
    .modo(o8.modo), .dir(o8.dir), .s_in(o8.s_in), .d(o8.d)
  );

  probador_registro #(.RUN_LEN(1)) dut1 (
    .clk(clk), .reset(reset), .start(start),
    .busy(o1.busy), .done(o1.done), .test_id(o1.test_id), .enb(o1.enb),
    .modo(o1.modo), .dir(o1.dir), .s_in(o1.s_in), .d(o1.d)
  );

  // Timeline model: ph 0 idle, 1 sequencing (t cycles since first LOAD), 2 finished.
  task automatic adv(input logic rst, input logic st, inout int ph, inout int t, input int len);
    if (rst) begin
      ph = 0; t = 0;
    end else if (ph == 1) begin
      t = t + 1;
      if (t == 5 * (len + 2)) ph = 2;
    end else if (st) begin
      ph = 1; t = 0;
    end
  endtask

  function automatic obs_t model_out(input int ph, input int t, input int len);
    obs_t e;
    int k, r;
    e = '{busy: 1'b0, done: 1'b0, test_id: 3'd0, enb: 5'b0, modo: 2'b11,
          dir: 1'b0, s_in: 1'b0, d: 4'hA};
    if (ph == 2) begin
      e.done = 1'b1; e.test_id = 3'd4; e.d = 4'hC;
    end else if (ph == 1) begin
      k = t / (len + 2);
      r = t % (len + 2);
      e.busy = 1'b1;
      e.test_id = 3'(k);
      e.d = seed_tbl[k];
      if (r == 0) begin
        e.enb = 5'(1 << k); e.modo = 2'b10;
      end else if (r <= len) begin
        e.enb = 5'(1 << k); e.modo = modo_tbl[k]; e.dir = dir_tbl[k];
        e.s_in = pat_bits[(r - 1) % 8];
      end
    end
    return e;
  endfunction

  task automatic step(input logic rst, input logic st);
    entry_t en;
    @(negedge clk);
    reset = rst;
    start = st;
    adv(rst, st, ph8, t8, 8);
    adv(rst, st, ph1, t1, 1);
    en.e8 = model_out(ph8, t8, 8);
    en.e1 = model_out(ph1, t1, 1);
    sb.push_back(en);
    @(posedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input obs_t a, input obs_t e);
    chk({tag, ".busy"},    a.busy,    e.busy);
    chk({tag, ".done"},    a.done,    e.done);
    chk({tag, ".test_id"}, a.test_id, e.test_id);
    chk({tag, ".enb"},     a.enb,     e.enb);
    chk({tag, ".modo"},    a.modo,    e.modo);
    chk({tag, ".dir"},     a.dir,     e.dir);
    chk({tag, ".s_in"},    a.s_in,    e.s_in);
    chk({tag, ".d"},       a.d,       e.d);
    chk({tag, ".onehot"},  int'($countones(a.enb) <= 1), 1);
  endtask

  int load8 = -1, load1 = -1;
  logic busy8_q = 1'b0, busy1_q = 1'b0, done8_q = 1'b0, done1_q = 1'b0;

  initial begin
    entry_t en;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() > 0) begin
        en = sb.pop_front();
        cmp("r8", o8, en.e8);
        cmp("r1", o1, en.e1);
        if (o8.enb == 5'b00001 && o8.modo == 2'b10 && !busy8_q) load8 = cyc;
        if (o1.enb == 5'b00001 && o1.modo == 2'b10 && !busy1_q) load1 = cyc;
        if (o8.done && !done8_q) chk("r8.done_latency", cyc - load8, 50);
        if (o1.done && !done1_q) chk("r1.done_latency", cyc - load1, 15);
        busy8_q = o8.busy; busy1_q = o1.busy;
        done8_q = o8.done; done1_q = o1.done;
      end
    end
  end

  initial begin
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 0; i < 42; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 0; i < 32; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/probador_registro.md
PROBADOR_REGISTRO -- requirements
Module: probador_registro

Interface
REQ-001 Parameter RUN_LEN, default 8, is the number of shift/rotate cycles per test; legal range 1..15.
REQ-002 Parameter PATTERN, default 8'b1011_0010, is the serial-in bit sequence, driven MSB first.
REQ-003 CLK  input  1  is the single clock; all state updates occur on its rising edge.
REQ-004 RESET  input  1  is the reset; it is synchronous and active-high.
REQ-005 START  input  1  is a one-cycle request to run the full five-test sequence.
REQ-006 BUSY  output  1  is high while a sequence is in progress.
REQ-007 DONE  output  1  is high once a sequence has completed; it is sticky.
REQ-008 TEST_ID  output  3  is the index of the current test, 0..4.
REQ-009 ENB  output  5  is a one-hot enable to the DUT pair of test k (bit k).
REQ-010 MODO  output  2  is the register mode: 00 shift, 01 rotate, 10 parallel load, 11 hold.
REQ-011 DIR  output  1  is the shift direction: 0 left, 1 right.
REQ-012 S_IN  output  1  is the serial input to the registers.
REQ-013 D  output  4  is the parallel-load data.

Function
REQ-014 The FSM states SHALL be IDLE, LOAD, RUN, GAP and FIN.
REQ-015 IDLE with START=1 SHALL go to LOAD with TEST_ID=0 on the next edge; otherwise the FSM stays in IDLE.
REQ-016 LOAD SHALL last 1 cycle, with ENB[TEST_ID]=1, MODO=10 and D=SEED[TEST_ID], then go to RUN.
REQ-017 SEED SHALL be {0:4'hA, 1:4'h1, 2:4'h8, 3:4'h3, 4:4'hC}.
REQ-018 RUN SHALL last RUN_LEN cycles with ENB[TEST_ID]=1, and MODO/DIR per test:
  - 0: MODO=11, DIR=0
  - 1: MODO=00, DIR=0
  - 2: MODO=00, DIR=1
  - 3: MODO=01, DIR=0
  - 4: MODO=01, DIR=1
REQ-019 In RUN, S_IN SHALL equal PATTERN[7 - (cnt mod 8)], where cnt is the run-cycle counter, 0-based; in all other states S_IN=0.
REQ-020 When cnt=RUN_LEN-1, RUN SHALL go to GAP and cnt SHALL clear.
REQ-021 GAP SHALL last 1 cycle with ENB=0 and MODO=11.
REQ-022 Leaving GAP, the FSM SHALL go to LOAD with TEST_ID+1 if TEST_ID<4; otherwise it goes to FIN.
REQ-023 FIN SHALL assert DONE=1 and BUSY=0, with ENB=0 and MODO=11.
REQ-024 FIN with START=1 SHALL clear DONE and go to LOAD with TEST_ID=0, restarting the sequence.
REQ-025 START SHALL be ignored in LOAD, RUN and GAP; BUSY=1 in exactly those states.
REQ-026 A full sequence SHALL take 5*(RUN_LEN+2) cycles from the first LOAD to the first FIN cycle; this is 50 cycles at default.
REQ-027 D SHALL equal SEED[TEST_ID] in every state so that the data is stable before and after LOAD; MODO SHALL be 11 outside LOAD and RUN.
REQ-028 At most one ENB bit SHALL be high in any cycle.
REQ-029 All outputs SHALL be registered, with no combinational path from START to any output.

Reset
REQ-030 RESET=1 at a rising edge SHALL force:
  - state=IDLE, TEST_ID=0, cnt=0
  - ENB=0, MODO=11, DIR=0, S_IN=0
  - D=4'hA, BUSY=0, DONE=0
REQ-031 RESET SHALL take priority over START and apply mid-sequence; no DUT enable SHALL be high in the cycle after reset.
REQ-032 RESET=1 together with START=1 SHALL leave the FSM in IDLE.

Structure
REQ-033 The state encoding, the MODO codes (SHIFT, ROTATE, LOAD, HOLD) and the SEED table SHALL live in a shared package that is also used by the shift-register models.
REQ-034 The block SHALL be a single module with no sub-modules; the seed/mode lookup is an internal function.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
  - Reset, then START pulse at cycle 2: LOAD at cycle 3 with ENB=00001, MODO=10, D=4'hA.
  - Full run at RUN_LEN=8: DONE rises exactly 50 cycles after the first LOAD, and ENB steps through 00001 to 10000.
  - Test 2 RUN: MODO=00, DIR=1, and S_IN reads 1,0,1,1,0,0,1,0 over cycles 0..7.
  - START pulses during RUN of test 1: no restart, and TEST_ID continues 1 to 2 after GAP.
  - RESET asserted in RUN of test 3: next cycle ENB=0, BUSY=0, TEST_ID=0, MODO=11.
  - START in FIN: DONE drops next cycle and LOAD of test 0 begins; with RUN_LEN=1, DONE appears 15 cycles after the first LOAD.
